// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and default parameters for the reset sequencer.
package reset_sequencer_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_HOLD_CYCLES = 16;
    localparam int unsigned DEF_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_SOFT  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

endpackage

// File: rtl/reset_sync.sv
// Async-clear shift chain: release of rst_n propagates to sync_done after STAGES edges.
module reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_done
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_done = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Domain reset generator: synchronised release, programmable hold stretch and
// a four-phase soft-reset handshake. Rst_out asserts asynchronously with Rst_n.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clock,
    input  logic Rst_n,
    input  logic soft_req,
    output logic soft_ack,
    output logic Rst_out,
    output logic ready
);

    state_e           state;
    state_e           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             rst_out_nx;
    logic             ready_nx;
    logic             soft_ack_nx;
    logic             sync_done;
    logic             cnt_last_c;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clock),
        .rst_n     (Rst_n),
        .sync_done (sync_done)
    );

    // Compare-equal terminates the hold count, so the counter never wraps.
    assign cnt_last_c = (cnt == CNT_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_RESET;
            cnt      <= '0;
            Rst_out  <= 1'b1;
            ready    <= 1'b0;
            soft_ack <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            Rst_out  <= rst_out_nx;
            ready    <= ready_nx;
            soft_ack <= soft_ack_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rst_out_nx  = Rst_out;
        ready_nx    = ready;
        soft_ack_nx = soft_ack;
        case (state)
            ST_RESET: begin
                cnt_nx = '0;
                if (sync_done) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_last_c) begin
                    state_nx   = ST_RUN;
                    cnt_nx     = '0;
                    rst_out_nx = 1'b0;
                    ready_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_nx = '0;
                if (soft_req) begin
                    state_nx   = ST_SOFT;
                    rst_out_nx = 1'b1;
                    ready_nx   = 1'b0;
                end
            end
            ST_SOFT: begin
                if (cnt_last_c) begin
                    state_nx    = ST_ACK;
                    cnt_nx      = '0;
                    rst_out_nx  = 1'b0;
                    soft_ack_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_ACK: begin
                cnt_nx = '0;
                if (!soft_req) begin
                    state_nx    = ST_RUN;
                    soft_ack_nx = 1'b0;
                    ready_nx    = 1'b1;
                end
            end
            default: begin
                state_nx    = ST_RESET;
                cnt_nx      = '0;
                rst_out_nx  = 1'b1;
                ready_nx    = 1'b0;
                soft_ack_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a SYNC_STAGES=3/HOLD_CYCLES=1
// instance share stimulus and are checked against a timestamp model every cycle.
module tb_reset_sequencer;

    localparam int A_SYNC = 2;
    localparam int A_HOLD = 16;
    localparam int B_SYNC = 3;
    localparam int B_HOLD = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic soft_req = 1'b0;
    logic rst_a, ready_a, ack_a;
    logic rst_b, ready_b, ack_b;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer u_dut_a (
        .clock    (clk),
        .Rst_n    (rst_n),
        .soft_req (soft_req),
        .soft_ack (ack_a),
        .Rst_out  (rst_a),
        .ready    (ready_a)
    );

    reset_sequencer #(
        .SYNC_STAGES (B_SYNC),
        .HOLD_CYCLES (B_HOLD),
        .CNT_W       (4)
    ) u_dut_b (
        .clock    (clk),
        .Rst_n    (rst_n),
        .soft_req (soft_req),
        .soft_ack (ack_b),
        .Rst_out  (rst_b),
        .ready    (ready_b)
    );

    // Model: edges since release, soft acceptance edge (-1 = none), ack flag.
    int m_n[2]    = '{0, 0};
    int m_soft[2] = '{-1, -1};
    bit m_ack[2]  = '{1'b0, 1'b0};

    function automatic int boot_len(int i);
        return (i == 0) ? (A_SYNC + 1 + A_HOLD) : (B_SYNC + 1 + B_HOLD);
    endfunction

    function automatic int hold_len(int i);
        return (i == 0) ? A_HOLD : B_HOLD;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_n[i]    = 0;
                m_soft[i] = -1;
                m_ack[i]  = 1'b0;
            end else begin
                m_n[i] = m_n[i] + 1;
                if (m_n[i] > boot_len(i)) begin
                    if (m_soft[i] >= 0) begin
                        if (m_n[i] == m_soft[i] + hold_len(i)) begin
                            m_soft[i] = -1;
                            m_ack[i]  = 1'b1;
                        end
                    end else if (m_ack[i]) begin
                        if (!soft_req) m_ack[i] = 1'b0;
                    end else if (soft_req) begin
                        m_soft[i] = m_n[i];
                    end
                end
            end
        end
    end

    function automatic logic exp_rst(int i);
        return !rst_n || (m_n[i] < boot_len(i)) || (m_soft[i] >= 0);
    endfunction

    function automatic logic exp_ready(int i);
        return rst_n && (m_n[i] >= boot_len(i)) && (m_soft[i] < 0) && !m_ack[i];
    endfunction

    function automatic logic exp_ack(int i);
        return rst_n && m_ack[i];
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests = tests + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if ($time > 2) begin
            chk("cmp_a_rst",   rst_a,   exp_rst(0));
            chk("cmp_a_ready", ready_a, exp_ready(0));
            chk("cmp_a_ack",   ack_a,   exp_ack(0));
            chk("cmp_b_rst",   rst_b,   exp_rst(1));
            chk("cmp_b_ready", ready_b, exp_ready(1));
            chk("cmp_b_ack",   ack_b,   exp_ack(1));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;

        // Power-on
        tick(3);
        chk("por_a_rst", rst_a, 1'b1);
        chk("por_a_ready", ready_a, 1'b0);
        chk("por_a_ack", ack_a, 1'b0);
        release_rst();
        tick(4);
        chk("b_edge4_rst", rst_b, 1'b1);
        tick(1);
        chk("b_edge5_rst", rst_b, 1'b0);
        chk("b_edge5_ready", ready_b, 1'b1);
        tick(13);
        chk("a_edge18_rst", rst_a, 1'b1);
        chk("a_edge18_ready", ready_a, 1'b0);
        tick(1);
        chk("a_edge19_rst", rst_a, 1'b0);
        chk("a_edge19_ready", ready_a, 1'b1);

        // Async re-assert between edges 10 and 11
        @(negedge clk);
        #1 rst_n = 1'b0;
        tick(2);
        release_rst();
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_a_rst", rst_a, 1'b1);
        chk("async_b_rst", rst_b, 1'b1);
        chk("async_b_ready", ready_b, 1'b0);
        tick(2);
        release_rst();
        tick(18);
        chk("rerel_a_edge18_rst", rst_a, 1'b1);
        tick(1);
        chk("rerel_a_edge19_rst", rst_a, 1'b0);
        chk("rerel_a_edge19_ready", ready_a, 1'b1);

        // Soft reset from RUN
        @(negedge clk);
        #1 soft_req = 1'b1;
        tick(1);
        chk("soft_a_e_rst", rst_a, 1'b1);
        chk("soft_a_e_ready", ready_a, 1'b0);
        chk("soft_b_e_rst", rst_b, 1'b1);
        tick(1);
        chk("soft_b_e1_rst", rst_b, 1'b0);
        chk("soft_b_e1_ack", ack_b, 1'b1);
        chk("soft_a_e1_rst", rst_a, 1'b1);
        tick(14);
        chk("soft_a_e15_rst", rst_a, 1'b1);
        chk("soft_a_e15_ack", ack_a, 1'b0);
        tick(1);
        chk("soft_a_e16_rst", rst_a, 1'b0);
        chk("soft_a_e16_ack", ack_a, 1'b1);
        chk("soft_a_e16_ready", ready_a, 1'b0);
        @(negedge clk);
        #1 soft_req = 1'b0;
        tick(1);
        chk("drop_a_ack", ack_a, 1'b0);
        chk("drop_a_ready", ready_a, 1'b1);
        chk("drop_b_ready", ready_b, 1'b1);

        // Early request held through power-on
        @(negedge clk);
        #1 rst_n = 1'b0;
        soft_req = 1'b1;
        tick(2);
        release_rst();
        tick(19);
        chk("early_a_edge19_rst", rst_a, 1'b0);
        chk("early_a_edge19_ready", ready_a, 1'b1);
        tick(1);
        chk("early_a_edge20_rst", rst_a, 1'b1);
        chk("early_a_edge20_ready", ready_a, 1'b0);
        tick(15);
        chk("early_a_edge35_rst", rst_a, 1'b1);
        tick(1);
        chk("early_a_edge36_rst", rst_a, 1'b0);
        chk("early_a_edge36_ack", ack_a, 1'b1);
        chk("early_b_ack", ack_b, 1'b1);

        // Reset during ACK
        #2 rst_n = 1'b0;
        #1;
        chk("ackrst_a_ack", ack_a, 1'b0);
        chk("ackrst_a_rst", rst_a, 1'b1);
        chk("ackrst_b_ack", ack_b, 1'b0);
        soft_req = 1'b0;
        tick(1);
        release_rst();
        tick(18);
        chk("ackrst_a_edge18_rst", rst_a, 1'b1);
        tick(1);
        chk("ackrst_a_edge19_rst", rst_a, 1'b0);
        chk("ackrst_a_edge19_ready", ready_a, 1'b1);

        // Pattern run checked cycle-by-cycle against the model
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1 soft_req = ((i / 7) % 3) != 0;
            if (i == 150) rst_n = 1'b0;
            if (i == 153) rst_n = 1'b1;
        end
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
